// File: rtl/square.sv
// Sequential shift-and-add squarer: one multiplier bit per ADD/SHIFT pair,
// 2*WIDTH+1 busy cycles, result held on y_o until the next completion.
`default_nettype none

module square #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   x_i,
  output logic [1:0]         busy_o,
  output logic [2*WIDTH-1:0] y_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ADD   = 2'b01,
    SHIFT = 2'b10
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  assign busy_o = state;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      cnt   <= '0;
      y_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a     <= {{WIDTH{1'b0}}, x_i};
            b     <= x_i;
            acc   <= '0;
            cnt   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          // The termination test lives in ADD so latency stays data-independent.
          if (cnt == CW'(WIDTH)) begin
            y_o   <= acc;
            state <= IDLE;
          end else begin
            if (b[0]) begin
              acc <= acc + a;
            end
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a     <= a << 1;
          b     <= b >> 1;
          cnt   <= cnt + 1'b1;
          state <= ADD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_square.sv
// Self-checking bench for square: cycle-level behavioural model plus directed and random stimulus.
`default_nettype none

module tb_square;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_i = 1'b0;
  logic           start_i = 1'b0;
  logic [W-1:0]   x_i = '0;
  logic [1:0]     busy_o;
  logic [2*W-1:0] y_o;

  logic           start4 = 1'b0;
  logic [3:0]     x4 = '0;
  logic [1:0]     busy4;
  logic [7:0]     y4;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit cmp_en = 1'b0;

  square #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .x_i(x_i),
    .busy_o(busy_o), .y_o(y_o)
  );

  square #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start4), .x_i(x4),
    .busy_o(busy4), .y_o(y4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: phase counts edges since acceptance; -1 means idle.
  int phase = -1;
  int m_sq = 0;
  int m_y = 0;

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      phase = -1;
      m_y   = 0;
    end else if (phase < 0) begin
      if (start_i) begin
        phase = 0;
        m_sq  = int'(x_i) * int'(x_i);
      end
    end else if (phase == 2 * W) begin
      m_y   = m_sq;
      phase = -1;
    end else begin
      phase++;
    end
  end

  function automatic int exp_busy();
    if (phase < 0) return 0;
    return (phase % 2 == 0) ? 1 : 2;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy_model", int'(busy_o), exp_busy());
      check("y_model", int'(y_o), m_y);
    end
  end

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o != 2'b00 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("wait_idle_timeout", n, 0);
  endtask

  task automatic run_one(input int x, input int exp_y, input string name);
    int n;
    @(negedge clk);
    start_i = 1'b1;
    x_i = W'(x);
    @(negedge clk);
    start_i = 1'b0;
    x_i = W'($urandom);
    wait_idle(n);
    check({name, "_latency"}, n, 17);
    check({name, "_y"}, int'(y_o), exp_y);
  endtask

  task automatic sq4(input int v, output int res);
    int n;
    @(negedge clk);
    start4 = 1'b1;
    x4 = 4'(v);
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (busy4 != 2'b00 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("sq4_timeout", n, 0);
    res = int'(y4);
  endtask

  initial begin
    int n;
    int r;
    int sq_r;
    int sq_r1;

    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy_o), 0);
    check("reset_y", int'(y_o), 0);
    rst_i = 1'b1;
    cmp_en = 1'b1;

    run_one(0, 0, "x0");
    run_one(15, 225, "x15");
    run_one(255, 65025, "x255");

    // Stray start during busy is dropped.
    @(negedge clk);
    start_i = 1'b1;
    x_i = 8'd200;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    start_i = 1'b1;
    x_i = 8'd3;
    @(negedge clk);
    start_i = 1'b0;
    x_i = 8'd77;
    wait_idle(n);
    check("ignored_start_y", int'(y_o), 40000);
    repeat (2) @(negedge clk);
    check("ignored_start_idle", int'(busy_o), 0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    start_i = 1'b1;
    x_i = 8'd100;
    @(negedge clk);
    start_i = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_i = 1'b0;
    #1;
    check("async_rst_busy", int'(busy_o), 0);
    check("async_rst_y", int'(y_o), 0);
    @(negedge clk);
    rst_i = 1'b1;
    run_one(12, 144, "after_rst");

    // Back-to-back with start held high.
    @(negedge clk);
    start_i = 1'b1;
    x_i = 8'd1;
    for (int k = 1; k <= 4; k++) begin
      n = 0;
      while (busy_o == 2'b00 && n < 10) begin
        n++;
        @(negedge clk);
      end
      if (k > 1) check("b2b_idle_gap", n, 1);
      x_i = 8'(k + 1);
      wait_idle(n);
      check("b2b_y", int'(y_o), k * k);
    end
    start_i = 1'b0;
    wait_idle(n);
    repeat (20) @(negedge clk);

    // Random traffic; the per-cycle compare carries the checking.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      start_i = ($urandom_range(0, 3) == 0);
      x_i = W'($urandom);
    end
    start_i = 1'b0;
    wait_idle(n);

    // Round trip with a 4-bit squarer against an integer root.
    for (int x = 0; x < 256; x += 7) begin
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      sq4(r, sq_r);
      check("rt_sq_r", sq_r, r * r);
      check("rt_le", int'(sq_r <= x), 1);
      if (r < 15) begin
        sq4(r + 1, sq_r1);
        check("rt_gt", int'(sq_r1 > x), 1);
      end
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/square.md
# square

Sequential integer squarer: on a start pulse it captures an unsigned WIDTH-bit operand and computes its exact square over 2·WIDTH+1 clock cycles using a shift-and-add datapath, one multiplier bit per two-state iteration. It is the inverse-direction companion of the team's iterative square-root unit: it produces y² so a root can be round-trip checked (root² ≤ x < (root+1)²), and it serves as a stand-alone small multiplier. It has the same start/busy/result handshake and two-phase state rhythm as the root unit, so both blocks can share one controller.

## Interface
- WIDTH, 8: operand width in bits; result is 2·WIDTH bits; legal range 2..16.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset (0 = reset asserted).
- start_i  input  1  request; sampled only in IDLE.
- x_i  input  WIDTH  unsigned operand; sampled on the accepting edge only.
- busy_o  output  2  current state code: 2'b00 IDLE, 2'b01 ADD, 2'b10 SHIFT.
- y_o  output  2·WIDTH  last completed square; held until the next completion.

## Operation
- Internal registers:
  - a: 2·WIDTH-bit multiplicand.
  - b: WIDTH-bit multiplier.
  - acc: 2·WIDTH-bit accumulator.
  - cnt: iteration counter, wide enough to hold WIDTH.
  - state: 2 bits. Code 2'b11 is unreachable; if it is ever entered, return to IDLE on the next edge.
- IDLE: if start_i = 1, load:
  - a ← zero-extended x_i
  - b ← x_i
  - acc ← 0
  - cnt ← 0
  - state ← ADD
  
  Otherwise hold.
- ADD:
  - If cnt = WIDTH: y_o ← acc, state ← IDLE.
  - Otherwise: if b[0] = 1, acc ← acc + a (2·WIDTH-bit add, which cannot overflow); state ← SHIFT.
- SHIFT: a ← a << 1, b ← b >> 1, cnt ← cnt + 1, state ← ADD.
- No early termination when b becomes 0; latency is data-independent.
- start_i is ignored in ADD and SHIFT. No queueing: a start pulse that arrives while busy is lost.
- x_i may change freely after the accepting edge; the result depends only on the captured value.
- y_o changes only on the final ADD edge, or on reset.

## Timing
- Reset (rst_i = 0, asynchronous, takes effect immediately regardless of clk_i):
  - state = IDLE, so busy_o = 2'b00.
  - y_o = 0.
  - a, b, acc, cnt = 0.
- Reset released mid-operation: the block is in IDLE with y_o = 0. The aborted operation is discarded and no partial result appears.
- Accepting edge E0: busy_o = 2'b01 from E0 onward.
- Edges E1..E2W alternate:
  - Odd-numbered edges are ADD decisions; busy_o = 2'b10 after each.
  - Even-numbered edges are SHIFTs; busy_o = 2'b01 after each.
- Edge E(2W+1): y_o is valid and busy_o = 2'b00 in the same cycle.
- busy_o ≠ 0 for exactly 2·WIDTH+1 cycles; this is 17 cycles for WIDTH = 8.
- Back-to-back: start_i held high continuously is accepted on the first edge after busy_o returns to 00, giving one idle cycle between operations. The new x_i is sampled on that edge.
- start_i and reset deassertion in the same cycle: the start is accepted only if rst_i is already 1 at the clock edge.

## Test plan
- Reset, then x_i = 0 with a start pulse: busy_o ≠ 0 for 17 cycles, then y_o = 0, busy_o = 00.
- x_i = 15, then x_i = 255, each started after completion: y_o = 225, then y_o = 65025; latency is 17 cycles each.
- Start with x_i = 200; at cycle 5 pulse start_i with x_i = 3 and also change x_i: the second pulse is ignored and y_o = 40000 at cycle 17.
- Start with x_i = 100; assert rst_i = 0 at cycle 9 (between clock edges): y_o = 0 and busy_o = 00 immediately. After release, start x_i = 12: y_o = 144.
- start_i held high with x_i cycling 1, 2, 3…: results 1, 4, 9… appear every 18 cycles, and y_o is stable between completions.
- Round trip with WIDTH = 4, for every x in 0..255: feed the 4-bit root r produced by the square-root unit into this block, and also r+1 where r < 15. Require r² ≤ x, and (r+1)² > x.
